// File: rtl/float_to_fixed_pkg.sv
// float_to_fixed_pkg: FP32 field constants, input classes and status flag layout
package float_to_fixed_pkg;
    localparam int         EXP_BIAS = 127;
    localparam int         MANT_W   = 23;
    localparam logic [7:0] EXP_MAX  = 8'hFF;

    typedef enum logic [2:0] {FP_ZERO, FP_DENORM, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    typedef struct packed {
        logic nan;
        logic sat;
        logic underflow;
        logic inexact;
    } flags_t;
endpackage

// File: rtl/float_to_fixed_pipe_unpack.sv
// fp32_unpack: splits an FP32 word into sign, unbiased exponent, mantissa with hidden bit and class
module fp32_unpack
    import float_to_fixed_pkg::*;
(
    input  logic [31:0]       i_float,
    output logic              o_sign,
    output logic signed [9:0] o_exp,
    output logic [23:0]       o_mant,
    output fp_class_e         o_class
);
    logic [7:0]  w_exp;
    logic [22:0] w_frac;

    assign w_exp  = i_float[30:23];
    assign w_frac = i_float[22:0];
    assign o_sign = i_float[31];
    assign o_exp  = $signed({2'b00, w_exp}) - 10'(EXP_BIAS);
    assign o_mant = {|w_exp, w_frac};

    always_comb
        o_class = (w_exp == EXP_MAX) ? ((|w_frac) ? FP_NAN : FP_INF) :
                  (w_exp == 8'd0)    ? ((|w_frac) ? FP_DENORM : FP_ZERO) : FP_NORM;
endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: two-stage FP32 to Q(INT_W.FRAC_W) converter with rounding, saturation and flags
module float_to_fixed_pipe
    import float_to_fixed_pkg::*;
#(
    parameter int INT_W     = 12,
    parameter int FRAC_W    = 0,
    parameter int SIGNED    = 0,
    parameter int ROUND_RNE = 1
)(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [31:0]              float_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [INT_W+FRAC_W-1:0]  fixed_o,
    output flags_t                   flags_o
);
    localparam int         OUT_W = INT_W + FRAC_W;
    localparam logic [32:0] LIM_P = (SIGNED != 0) ? (33'd1 << (OUT_W - 1)) - 33'd1 : (33'd1 << OUT_W) - 33'd1;
    localparam logic [32:0] LIM_N = (SIGNED != 0) ? (33'd1 << (OUT_W - 1)) : 33'd0;
    localparam logic [32:0] NEG_N = ~LIM_N + 33'd1;
    localparam logic [OUT_W-1:0] MAX_V = LIM_P[OUT_W-1:0];
    localparam logic [OUT_W-1:0] MIN_V = NEG_N[OUT_W-1:0];

    logic              w_adv;
    logic              w_sign;
    logic signed [9:0] w_exp;
    logic [23:0]       w_mant;
    fp_class_e         w_cls;
    logic signed [10:0] w_t;
    logic [63:0]       w_shifted;
    logic              w_big;

    logic              r_s1_valid;
    logic              r_s1_sign;
    fp_class_e         r_s1_cls;
    logic              r_s1_big;
    logic [31:0]       r_s1_mag;
    logic              r_s1_guard;
    logic              r_s1_sticky;

    logic              w_rnd;
    logic              w_ovf;
    logic [32:0]       w_rmag;
    logic [32:0]       w_nmag;
    logic [OUT_W-1:0]  w_fix;
    flags_t            w_flg;

    assign w_adv     = !m_valid_o || m_ready_i;
    assign s_ready_o = w_adv;

    fp32_unpack u_unpack (
        .i_float (float_i),
        .o_sign  (w_sign),
        .o_exp   (w_exp),
        .o_mant  (w_mant),
        .o_class (w_cls)
    );

    // Mantissa sits at bit 0 of a 64b word whose low 32 bits are fraction; w_t places it.
    assign w_t       = 11'(w_exp) + 11'(FRAC_W + 32 - MANT_W);
    assign w_big     = w_exp >= 10'(INT_W);
    assign w_shifted = (w_t < 11'sd0) ? 64'd0 : ({40'd0, w_mant} << w_t[5:0]);

    assign w_rnd  = (ROUND_RNE != 0) && r_s1_guard && (r_s1_sticky || r_s1_mag[0]);
    assign w_rmag = {1'b0, r_s1_mag} + 33'(w_rnd);
    assign w_nmag = 33'd0 - w_rmag;
    assign w_ovf  = r_s1_big || (w_rmag > (r_s1_sign ? LIM_N : LIM_P));

    always_comb begin
        w_fix = '0;
        w_flg = '0;
        if (r_s1_cls == FP_NAN)
            w_flg.nan = 1'b1;
        else if (r_s1_cls == FP_INF || (r_s1_sign && SIGNED == 0 && r_s1_cls != FP_ZERO) ||
                 (r_s1_cls == FP_NORM && w_ovf)) begin
            w_fix     = r_s1_sign ? MIN_V : MAX_V;
            w_flg.sat = 1'b1;
        end else if (r_s1_cls == FP_DENORM || (r_s1_cls == FP_NORM && w_rmag == 33'd0))
            w_flg.underflow = 1'b1;
        else if (r_s1_cls == FP_NORM) begin
            w_fix         = r_s1_sign ? w_nmag[OUT_W-1:0] : w_rmag[OUT_W-1:0];
            w_flg.inexact = r_s1_guard || r_s1_sticky;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            m_valid_o  <= 1'b0;
            fixed_o    <= '0;
            flags_o    <= '0;
        end else if (w_adv) begin
            r_s1_valid <= s_valid_i;
            m_valid_o  <= r_s1_valid;
            if (s_valid_i) begin
                r_s1_sign   <= w_sign;
                r_s1_cls    <= w_cls;
                r_s1_big    <= w_big;
                r_s1_mag    <= w_shifted[63:32];
                r_s1_guard  <= (w_t < 11'sd0) ? 1'b0 : w_shifted[31];
                r_s1_sticky <= (w_t < 11'sd0) ? |w_mant : |w_shifted[30:0];
            end
            if (r_s1_valid) begin
                fixed_o <= w_fix;
                flags_o <= w_flg;
            end
        end
    end
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// tb_float_to_fixed_pipe: three parameter sets driven in lockstep, scoreboard-checked outputs
module tb_float_to_fixed_pipe;
    localparam int N = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b1;
    logic [31:0] fin = 32'd0;
    logic [2:0]  srdy;
    logic [2:0]  mval;
    logic [11:0] fx_a, fx_b, fx_c;
    logic [3:0]  fl_a, fl_b, fl_c;
    logic [47:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    // expected words are {flags, fixed}: flags nibble = {nan, sat, underflow, inexact}
    logic [31:0] vin [N] = '{32'h40A00000, 32'h45800000, 32'hBFC00000, 32'hC3000000, 32'hC3010000,
                             32'h40200000, 32'h40600000, 32'h3F000000, 32'h7FC00000, 32'hFF800000,
                             32'h00000001, 32'h80000000, 32'h7F800000, 32'h3FC00000, 32'h3F400000,
                             32'h457FF000, 32'h457FF800, 32'hC2FF0000, 32'h3D800000, 32'h3D000000};
    logic [15:0] ea [N] = '{16'h0005, 16'h4FFF, 16'h4000, 16'h4000, 16'h4000,
                            16'h1002, 16'h1004, 16'h2000, 16'h8000, 16'h4000,
                            16'h2000, 16'h0000, 16'h4FFF, 16'h1002, 16'h1001,
                            16'h0FFF, 16'h4FFF, 16'h4000, 16'h2000, 16'h2000};
    logic [15:0] eb [N] = '{16'h0050, 16'h47FF, 16'h0FE8, 16'h0800, 16'h4800,
                            16'h0028, 16'h0038, 16'h0008, 16'h8000, 16'h4800,
                            16'h2000, 16'h0000, 16'h47FF, 16'h0018, 16'h000C,
                            16'h47FF, 16'h47FF, 16'h0808, 16'h0001, 16'h2000};
    logic [15:0] ec [N] = '{16'h0005, 16'h4FFF, 16'h4000, 16'h4000, 16'h4000,
                            16'h1002, 16'h1003, 16'h2000, 16'h8000, 16'h4000,
                            16'h2000, 16'h0000, 16'h4FFF, 16'h1001, 16'h2000,
                            16'h0FFF, 16'h1FFF, 16'h4000, 16'h2000, 16'h2000};

    always #5 clk = ~clk;

    float_to_fixed_pipe #(.INT_W(12), .FRAC_W(0), .SIGNED(0), .ROUND_RNE(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(srdy[0]), .float_i(fin),
        .m_valid_o(mval[0]), .m_ready_i(m_ready), .fixed_o(fx_a), .flags_o(fl_a));
    float_to_fixed_pipe #(.INT_W(8), .FRAC_W(4), .SIGNED(1), .ROUND_RNE(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(srdy[1]), .float_i(fin),
        .m_valid_o(mval[1]), .m_ready_i(m_ready), .fixed_o(fx_b), .flags_o(fl_b));
    float_to_fixed_pipe #(.INT_W(12), .FRAC_W(0), .SIGNED(0), .ROUND_RNE(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(srdy[2]), .float_i(fin),
        .m_valid_o(mval[2]), .m_ready_i(m_ready), .fixed_o(fx_c), .flags_o(fl_c));

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic send(input int i);
        int   n = 0;
        logic acc = 1'b0;
        s_valid = 1'b1;
        fin = vin[i];
        do begin
            @(negedge clk);
            acc = srdy[0];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (acc) sb.push_back({ea[i], eb[i], ec[i]});
        else chk("send_timeout", 16'd0, 16'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 16'(sb.size()), 16'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_lockstep", {13'd0, mval}, (mval[0] ? 16'd7 : 16'd0));
            if (mval[0]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {fl_a, fx_a}, 16'hDEAD);
                end else begin
                    chk("out_a", {fl_a, fx_a}, sb[0][47:32]);
                    chk("out_b", {fl_b, fx_b}, sb[0][31:16]);
                    chk("out_c", {fl_c, fx_c}, sb[0][15:0]);
                    if (m_ready) void'(sb.pop_front());
                    else chk("stall_s_ready", {13'd0, srdy}, 16'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {13'd0, mval}, 16'd0);
        chk("rst_out_a", {fl_a, fx_a}, 16'd0);
        chk("rst_out_b", {fl_b, fx_b}, 16'd0);
        rst_n = 1'b1;
        chk("rst_s_ready", {13'd0, srdy}, 16'd7);

        send(0);
        chk("latency_c1", {13'd0, mval}, 16'd0);
        @(posedge clk);
        #1;
        chk("latency_c2", {13'd0, mval}, 16'd7);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 1; i < N; i++) send(i);
        drain();

        fork
            for (int i = 5; i < 9; i++) send(i);
            begin
                m_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();

        fork
            for (int i = 10; i < 18; i++) send(i);
            for (int k = 0; k < 14; k++) begin
                m_ready = k[0];
                @(posedge clk);
                #1;
            end
        join
        m_ready = 1'b1;
        drain();

        m_ready = 1'b0;
        send(1);
        send(2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk("midrst_valid", {13'd0, mval}, 16'd0);
        chk("midrst_out_a", {fl_a, fx_a}, 16'd0);
        chk("midrst_out_b", {fl_b, fx_b}, 16'd0);
        chk("midrst_out_c", {fl_c, fx_c}, 16'd0);
        m_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(3);
        send(6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_to_fixed_pipe.md
Name: float_to_fixed_pipe

Overview:
Parametrised, pipelined successor to the single-channel FP32-to-12-bit converter. Converts IEEE-754 single-precision inputs to a configurable fixed-point format (Q INT_W.FRAC_W), signed or unsigned. Rounding is selectable, saturation is explicit and status flags are reported. Sits between the float-domain datapath and the fixed-point ADC/multiplier path, with valid/ready handshakes on both sides.

Parameters:
INT_W, 12, integer bits of output (includes sign bit when SIGNED=1); 1..31
FRAC_W, 0, fractional bits of output; 0..16; INT_W+FRAC_W <= 32
SIGNED, 0, 1 = two's-complement output, 0 = unsigned output
ROUND_RNE, 1, 1 = round-to-nearest-even, 0 = truncate toward zero

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
s_valid_i  in  1  input word valid
s_ready_o  out  1  converter accepts input this cycle
float_i  in  32  FP32 input
m_valid_o  out  1  output word valid
m_ready_i  in  1  downstream accepts output
fixed_o  out  INT_W+FRAC_W  fixed-point result
flags_o  out  4  {nan, sat, underflow, inexact}

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_ni is synchronous, active-low.
- Reset: m_valid_o=0, fixed_o=0, flags_o=0, both stage valids cleared. Reset mid-operation discards in-flight words. s_ready_o=1 on the first cycle after release.
- Pipeline: 2 stages. S1 unpacks the input, classifies it and does the aligning barrel shift, keeping guard and sticky bits. S2 rounds, saturates and registers the outputs.
- Latency: 2 cycles from accept (s_valid_i & s_ready_o) to m_valid_o when not stalled. Throughput is 1 word/cycle.
- Handshake: adv = !m_valid_o | m_ready_i; s_ready_o = adv. Pipeline stages advance only when adv=1.
- While m_valid_o=1 & m_ready_i=0, fixed_o and flags_o hold stable. Bubbles propagate; no word is dropped or duplicated.
- Output range: OUT_W = INT_W+FRAC_W; ideal result = value * 2^FRAC_W.
  - Unsigned range: 0..2^OUT_W-1.
  - Signed range: -2^(OUT_W-1)..2^(OUT_W-1)-1.
- Alignment: shift amount = (exp-127-23+FRAC_W); positive = left shift, negative = right shift. Bits shifted out feed guard/sticky.
- Rounding (ROUND_RNE=1): increment the magnitude if guard=1 and (sticky=1 or LSB=1).
  - A rounding carry that exceeds the range saturates.
- Truncation (ROUND_RNE=0): drop the discarded bits; magnitude is never incremented.
- inexact: set when any discarded bit is nonzero and the result is not NaN/saturated.
- Special cases:
  - exp=0xFF, mant!=0 (NaN): fixed_o=0, nan=1.
  - +Inf: max value, sat=1. -Inf: min value (signed) or 0 (unsigned), sat=1.
  - exp=0 (zero or denormal): flushed to 0. underflow=1 if mant!=0.
  - Nonzero finite input that rounds to 0: fixed_o=0, underflow=1.
  - Magnitude above range: clamp to max/min, sat=1.
  - Negative input with SIGNED=0: fixed_o=0, sat=1 (-0.0 gives 0 with no flag).
  - Signed negative result: two's complement of the rounded magnitude. Exactly -2^(OUT_W-1) is legal and not saturated.
- Flags are exclusive in priority nan > sat > underflow > inexact; exactly one or none is set per word.

Decomposition:
- float_to_fixed_pkg:
  - FP32 field constants: EXP_BIAS=127, MANT_W=23, EXP_MAX=8'hFF.
  - fp_class_e enum {FP_ZERO, FP_DENORM, FP_NORM, FP_INF, FP_NAN}.
  - flags_t packed struct {nan, sat, underflow, inexact}.
- One sub-module: fp32_unpack. Combinational: float_i -> sign, unbiased exponent (signed 10b), 24b mantissa with hidden bit, fp_class_e. Instantiated in S1.

Test Plan:
- Default params: feed 0x40A00000 (5.0) -> fixed_o=0x005, flags=0, m_valid_o exactly 2 cycles after accept. Feed 0x45800000 (4096.0) -> 0xFFF, sat=1.
- INT_W=8, FRAC_W=4, SIGNED=1: 0xBFC00000 (-1.5) -> 0xFE8, flags=0. 0xC3000000 (-128.0) -> 0x800, no sat. 0xC3010000 (-129.0) -> 0x800, sat=1.
- ROUND_RNE=1, FRAC_W=0: 0x40200000 (2.5) -> 2; 0x40600000 (3.5) -> 4; 0x3F000000 (0.5) -> 0, underflow=1. With ROUND_RNE=0: 2.5 -> 2, inexact=1; 3.5 -> 3, inexact=1.
- Specials: 0x7FC00000 -> 0, nan=1. 0xFF800000 with SIGNED=0 -> 0, sat=1. 0x00000001 -> 0, underflow=1. 0x80000000 -> 0, flags=0.
- Backpressure: stream 4 words, hold m_ready_i=0 for 3 cycles -> fixed_o stable, s_ready_o=0 while stalled with a word held at the output. Release -> all 4 words emerge in order, none lost or duplicated.
- Reset mid-stream: rst_ni=0 for 1 cycle with both stages full -> next cycle m_valid_o=0, fixed_o=0, flags_o=0; no stale word appears afterwards.
